// File: rtl/conv_3x3_if.sv
// Pixel stream bundle between the line-buffer stage and the 3x3 filter.
// The slave side is the filter; the master side feeds windows and takes results.
interface conv_3x3_if;
    logic [71:0] pixel_data_in;
    logic        pixel_data_valid_in;
    logic [1:0]  mode_in;
    logic [7:0]  pixel_data_out;
    logic        pixel_data_valid_out;
    logic        line_done_out;
    logic        frame_done_out;
    logic        busy_out;

    modport slave (
        input  pixel_data_in, pixel_data_valid_in, mode_in,
        output pixel_data_out, pixel_data_valid_out, line_done_out, frame_done_out, busy_out
    );

    modport master (
        output pixel_data_in, pixel_data_valid_in, mode_in,
        input  pixel_data_out, pixel_data_valid_out, line_done_out, frame_done_out, busy_out
    );
endinterface

// File: rtl/conv_3x3.sv
// 3x3 kernel filter (pass/gaussian/sharpen/edge) with a fixed 3-cycle pipeline,
// per-frame mode latching and output line/frame position tracking.
module conv_3x3 #(
    parameter int LINE_WIDTH  = 320,
    parameter int FRAME_LINES = 238
) (
    input logic       clk_in,
    input logic       rst_in,
    conv_3x3_if.slave bus
);
    localparam int COL_W  = (LINE_WIDTH  > 1) ? $clog2(LINE_WIDTH)  : 1;
    localparam int LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  mode_reg, mode_next;
    logic        start;

    logic [7:0]  pix [0:8];
    logic [9:0]  corner_sum, edge_sum;

    logic        v1_reg;
    logic [1:0]  mode1_reg;
    logic [9:0]  corner1_reg, edge1_reg;
    logic [7:0]  centre1_reg;

    logic [11:0] gauss_sum;
    logic [7:0]  gauss_val;
    logic [12:0] sharp_val;
    logic [11:0] centre_x4, edge_abs;
    logic [12:0] res2_next;

    logic        v2_reg;
    logic [12:0] res2_reg;
    logic [7:0]  clamp_val;

    logic [7:0]  out_reg;
    logic        valid_out_reg, line_done_reg, frame_done_reg;
    logic [COL_W-1:0]  col_reg;
    logic [LINE_W-1:0] line_reg;
    logic        col_last, line_last;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_unpack
            assign pix[gi] = bus.pixel_data_in[8*gi +: 8];
        end
    endgenerate

    assign corner_sum = 10'(pix[0]) + 10'(pix[2]) + 10'(pix[6]) + 10'(pix[8]);
    assign edge_sum   = 10'(pix[1]) + 10'(pix[3]) + 10'(pix[5]) + 10'(pix[7]);

    // A new frame may begin in the same cycle the previous one finishes.
    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        start      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.pixel_data_valid_in) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (frame_done_reg) begin
                    if (bus.pixel_data_valid_in) begin
                        start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (start) begin
            mode_next = bus.mode_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
            mode_reg  <= 2'd0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
        end
    end

    // S1: neighbour sums, centre, and the mode this window is tagged with.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v1_reg      <= 1'b0;
            mode1_reg   <= 2'd0;
            corner1_reg <= 10'd0;
            edge1_reg   <= 10'd0;
            centre1_reg <= 8'd0;
        end else begin
            v1_reg      <= bus.pixel_data_valid_in;
            mode1_reg   <= mode_next;
            corner1_reg <= corner_sum;
            edge1_reg   <= edge_sum;
            centre1_reg <= pix[4];
        end
    end

    // S2: kernel results kept wide (two's complement for sharpen) until the clamp.
    always_comb begin
        gauss_sum = 12'(corner1_reg) + {1'b0, edge1_reg, 1'b0} + {2'b00, centre1_reg, 2'b00};
        gauss_val = 8'(gauss_sum >> 4);
        sharp_val = 13'(centre1_reg) * 13'd5 - 13'(edge1_reg);
        centre_x4 = {2'b00, centre1_reg, 2'b00};
        edge_abs  = (centre_x4 >= 12'(edge1_reg)) ? centre_x4 - 12'(edge1_reg)
                                                   : 12'(edge1_reg) - centre_x4;
        res2_next = 13'(centre1_reg);
        case (mode1_reg)
            2'd0:    res2_next = 13'(centre1_reg);
            2'd1:    res2_next = 13'(gauss_val);
            2'd2:    res2_next = sharp_val;
            default: res2_next = {1'b0, edge_abs};
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v2_reg   <= 1'b0;
            res2_reg <= 13'd0;
        end else begin
            v2_reg   <= v1_reg;
            res2_reg <= res2_next;
        end
    end

    // S3: clamp to 0..255 and track output position.
    assign clamp_val = res2_reg[12]    ? 8'd0 :
                       (|res2_reg[11:8]) ? 8'd255 : res2_reg[7:0];
    assign col_last  = (col_reg  == COL_W'(LINE_WIDTH - 1));
    assign line_last = (line_reg == LINE_W'(FRAME_LINES - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_reg        <= 8'd0;
            valid_out_reg  <= 1'b0;
            line_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            col_reg        <= '0;
            line_reg       <= '0;
        end else begin
            valid_out_reg  <= v2_reg;
            line_done_reg  <= v2_reg && col_last;
            frame_done_reg <= v2_reg && col_last && line_last;
            if (v2_reg) begin
                out_reg <= clamp_val;
                if (col_last) begin
                    col_reg  <= '0;
                    line_reg <= line_last ? '0 : line_reg + LINE_W'(1);
                end else begin
                    col_reg <= col_reg + COL_W'(1);
                end
            end
        end
    end

    assign bus.pixel_data_out       = out_reg;
    assign bus.pixel_data_valid_out = valid_out_reg;
    assign bus.line_done_out        = line_done_reg;
    assign bus.frame_done_out       = frame_done_reg;
    assign bus.busy_out             = (state_reg == RUN);
endmodule

// File: doc/conv_3x3.md
CONV_3X3 -- requirements
Module: conv_3x3

Interface
REQ-001 Parameter LINE_WIDTH, default 320: output pixels per line.
REQ-002 Parameter FRAME_LINES, default 238: output lines per frame (240-line image minus 2 border lines).
REQ-003 clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 rst_in  input  1  reset; synchronous, active-high.
REQ-005 pixel_data_in  input  72  3x3 window from the line-buffer stage. Byte i = bits [8i+7:8i], i=0..8. Row r = i/3, where row 0 is the oldest line. Column c = i%3. Centre pixel is i=4.
REQ-006 pixel_data_valid_in  input  1  window valid this cycle; there is no backpressure.
REQ-007 mode_in  input  2  kernel select: 0 pass, 1 gaussian, 2 sharpen, 3 edge.
REQ-008 pixel_data_out  output  8  filtered pixel.
REQ-009 pixel_data_valid_out  output  1  pixel_data_out is valid.
REQ-010 line_done_out  output  1  one-cycle pulse with the last output pixel of each line.
REQ-011 frame_done_out  output  1  one-cycle pulse with the last output pixel of each frame.
REQ-012 busy_out  output  1  high while the FSM is in RUN.

Function
REQ-013 Kernels, applied to the same window:
- pass = p4.
- gaussian = (p0+2p1+p2+2p3+4p4+2p5+p6+2p7+p8)>>4; 12-bit unsigned sum; never exceeds 255.
- sharpen = 5p4-(p1+p3+p5+p7); 13-bit signed; clamped to 0..255.
- edge = |4p4-(p1+p3+p5+p7)|; 12-bit; clamped to 255.
REQ-014 Fixed 3-cycle latency from a valid window to its output.
- S1: register neighbour sums and the centre.
- S2: combine and scale.
- S3: clamp and register the output.
REQ-015 pixel_data_valid_out equals pixel_data_valid_in delayed exactly 3 cycles; gaps in the input are preserved.
REQ-016 When pixel_data_valid_out is 0, pixel_data_out holds its last value.
REQ-017 FSM states: IDLE, RUN.
- IDLE -> RUN on the first valid window.
- RUN -> IDLE in the cycle frame_done_out is asserted.
REQ-018 Mode latching:
- mode_in is latched in the same cycle as the IDLE->RUN transition.
- The latched mode applies to the whole frame.
- Changes to mode_in during RUN are ignored.
REQ-019 The mode travels with each pixel through the pipeline. Pixels still in flight at a frame boundary use the mode of their own frame.
REQ-020 Output column counter, 0..LINE_WIDTH-1:
- increments on each output valid;
- line_done_out = 1 when the counter equals LINE_WIDTH-1 with valid;
- then wraps to 0.
REQ-021 Output line counter, 0..FRAME_LINES-1:
- increments on line_done_out;
- frame_done_out = 1 when line_done_out and line counter = FRAME_LINES-1 coincide;
- then both counters wrap to 0.
REQ-022 A valid input window in the same cycle as RUN->IDLE starts a new frame: it latches the new mode and stays in RUN (no IDLE cycle).
REQ-023 Counters count outputs, not inputs. A window that is in flight when frame_done_out fires belongs to the next frame.
REQ-024 All arithmetic is unsigned except the sharpen intermediate. There is no truncation before the clamp.

Reset
REQ-025 While rst_in=1, on the next clock edge:
- pixel_data_out=0, all outputs low;
- FSM=IDLE;
- counters=0;
- pipeline valid bits=0;
- latched mode=0.
REQ-026 Reset mid-frame discards in-flight pixels. No valid output appears until 3 cycles after the first post-reset valid window.
REQ-027 Assertion of rst_in overrides every other event in that cycle.

Verification
REQ-028 Mode 0, window bytes 0..8 = 10,20,...,90, valid for 1 cycle -> 3 cycles later valid_out=1 and out=50, for exactly 1 cycle.
REQ-029 Mode 1 with all bytes 255 -> out=255. Mode 1 with p4=160, rest 0 -> out=40.
REQ-030 Sharpen clamps: mode 2 with p4=200, p1=p3=p5=p7=0 -> out=255. Mode 2 with p4=0, neighbours=100 -> out=0. Mode 3 with p4=0, neighbours=50 -> out=200.
REQ-031 LINE_WIDTH=4, FRAME_LINES=2:
- 8 valid windows with 1-cycle gaps -> line_done_out on output pixels 4 and 8 only;
- frame_done_out on output 8;
- busy_out falls the next cycle.
REQ-032 Latch timing: start frame in mode 1, switch mode_in to 2 mid-frame -> the whole frame uses mode 1. The next frame, started in the cycle after frame_done_out, uses mode 2.
REQ-033 Stream windows continuously, pulse rst_in for 1 cycle at input pixel 5:
- no valid_out for the 3 cycles after reset;
- counters restart, so line_done_out appears LINE_WIDTH outputs later.
